// File: rtl/traffic_input_conditioner.sv
// rtl/traffic_input_conditioner.sv - clock divider, input conditioning and pedestrian request latch
//
// Front-end for the 1 Hz traffic-light controller.
//
// Ports:
//   CLOCK_50    in   system clock
//   rst_n       in   synchronous active-low reset
//   key_n       in   raw pedestrian button, 0 = pressed
//   car_sw      in   raw car sensor, 1 = car
//   ped_clear   in   one-cycle grant pulse from the controller
//   tick        out  one-cycle pulse every DIV = CLK_HZ/TICK_HZ cycles
//   slow_clk    out  square wave at TICK_HZ, falls at the end of the tick cycle
//   ped_press   out  one-cycle pulse per accepted (debounced) press
//   ped_req     out  latched pedestrian request
//   car_present out  debounced car level (optionally stretched)
//   wait_secs   out  ticks elapsed since ped_req was set, saturating at 255
//
// Optional feature: define TIC_CAR_HOLD_EN to stretch car_present for
// CAR_HOLD_TICKS ticks after the debounced car signal drops.

module traffic_input_conditioner #(
   parameter int CLK_HZ          = 50000000,
   parameter int TICK_HZ         = 1,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CAR_HOLD_TICKS  = 3
) (
   input  logic       CLOCK_50,
   input  logic       rst_n,
   input  logic       key_n,
   input  logic       car_sw,
   input  logic       ped_clear,
   output logic       tick,
   output logic       slow_clk,
   output logic       ped_press,
   output logic       ped_req,
   output logic       car_present,
   output logic [7:0] wait_secs
);

   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int CW  = $clog2(DIV);
   localparam int DW  = $clog2(DEBOUNCE_CYCLES + 1);

   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);
   localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

   if ((DIV % 2) != 0 || DIV < 4) begin : g_bad_div
      $error("traffic_input_conditioner: CLK_HZ/TICK_HZ must be even and >= 4");
   end
   if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
      $error("traffic_input_conditioner: DEBOUNCE_CYCLES must be >= 1");
   end
   if (CAR_HOLD_TICKS < 0 || CAR_HOLD_TICKS > 255) begin : g_bad_hold
      $error("traffic_input_conditioner: CAR_HOLD_TICKS must be 0..255");
   end

   // ---------------------------------------------------------------- divider
   logic [CW-1:0] div_cnt;

   always_ff @(posedge CLOCK_50) begin
      if (!rst_n) begin
         div_cnt  <= '0;
         slow_clk <= 1'b0;
      end else begin
         div_cnt <= (div_cnt == CNT_LAST) ? '0 : div_cnt + CW'(1);
         if (div_cnt == CNT_HALF || div_cnt == CNT_LAST)
            slow_clk <= ~slow_clk;
      end
   end

   assign tick = (div_cnt == CNT_LAST);

   // ---------------------------------------------------------- synchronisers
   logic key_s1, key_s2;
   logic car_s1, car_s2;

   always_ff @(posedge CLOCK_50) begin
      if (!rst_n) begin
         key_s1 <= 1'b1;
         key_s2 <= 1'b1;
         car_s1 <= 1'b0;
         car_s2 <= 1'b0;
      end else begin
         key_s1 <= key_n;
         key_s2 <= key_s1;
         car_s1 <= car_sw;
         car_s2 <= car_s1;
      end
   end

   // --------------------------------------------------------------- debounce
   // The accepted level changes on the edge where the mismatch counter would
   // reach DEBOUNCE_CYCLES, so the counter itself never holds that value.
   logic [DW-1:0] key_cnt, car_cnt;
   logic          key_db, car_db;

   always_ff @(posedge CLOCK_50) begin
      if (!rst_n) begin
         key_cnt <= '0;
         key_db  <= 1'b1;
      end else if (key_s2 == key_db) begin
         key_cnt <= '0;
      end else if (key_cnt == DB_LAST) begin
         key_cnt <= '0;
         key_db  <= key_s2;
      end else begin
         key_cnt <= key_cnt + DW'(1);
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (!rst_n) begin
         car_cnt <= '0;
         car_db  <= 1'b0;
      end else if (car_s2 == car_db) begin
         car_cnt <= '0;
      end else if (car_cnt == DB_LAST) begin
         car_cnt <= '0;
         car_db  <= car_s2;
      end else begin
         car_cnt <= car_cnt + DW'(1);
      end
   end

   // ------------------------------------------------------ press and request
   logic key_db_d;
   logic req_q;

   always_ff @(posedge CLOCK_50) begin
      if (!rst_n) begin
         key_db_d  <= 1'b1;
         ped_press <= 1'b0;
      end else begin
         key_db_d  <= key_db;
         ped_press <= key_db_d & ~key_db;
      end
   end

   // The press is folded into ped_req combinationally so the request is
   // visible in the press cycle and a clear in that same cycle loses.
   assign ped_req = req_q | ped_press;

   always_ff @(posedge CLOCK_50) begin
      if (!rst_n) begin
         req_q     <= 1'b0;
         wait_secs <= 8'd0;
      end else begin
         req_q <= ped_press | (req_q & ~ped_clear);
         if (ped_press || ped_clear || !ped_req)
            wait_secs <= 8'd0;
         else if (tick && wait_secs != 8'hFF)
            wait_secs <= wait_secs + 8'd1;
      end
   end

   // ------------------------------------------------------------ car output
`ifdef TIC_CAR_HOLD_EN
   localparam int HW = (CAR_HOLD_TICKS > 0) ? $clog2(CAR_HOLD_TICKS + 1) : 1;
   localparam logic [HW-1:0] HOLD_LOAD = HW'(CAR_HOLD_TICKS);

   logic [HW-1:0] hold_cnt;
   logic          car_fall;

   // Debounced car is about to drop on this edge.
   assign car_fall = car_db & (car_s2 == 1'b0) & (car_cnt == DB_LAST);

   always_ff @(posedge CLOCK_50) begin
      if (!rst_n)
         hold_cnt <= '0;
      else if (car_fall)
         hold_cnt <= HOLD_LOAD;
      else if (car_db)
         hold_cnt <= '0;
      else if (tick && hold_cnt != '0)
         hold_cnt <= hold_cnt - HW'(1);
   end

   assign car_present = car_db | (hold_cnt != '0);
`else
   assign car_present = car_db;
`endif

endmodule

// File: tb/tb_traffic_input_conditioner.sv
// tb/tb_traffic_input_conditioner.sv - self-checking bench for traffic_input_conditioner
module tb_traffic_input_conditioner;

   localparam int CLK_HZ   = 20;
   localparam int TICK_HZ  = 1;
   localparam int DB       = 4;
   localparam int HOLD     = 3;
   localparam int DIV      = CLK_HZ / TICK_HZ;

   logic       clk;
   logic       rst_n;
   logic       key_n;
   logic       car_sw;
   logic       ped_clear;
   logic       tick;
   logic       slow_clk;
   logic       ped_press;
   logic       ped_req;
   logic       car_present;
   logic [7:0] wait_secs;

   int checks = 0;
   int errors = 0;

   traffic_input_conditioner #(
      .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ),
      .DEBOUNCE_CYCLES(DB), .CAR_HOLD_TICKS(HOLD)
   ) dut (
      .CLOCK_50(clk), .rst_n(rst_n), .key_n(key_n), .car_sw(car_sw),
      .ped_clear(ped_clear), .tick(tick), .slow_clk(slow_clk),
      .ped_press(ped_press), .ped_req(ped_req), .car_present(car_present),
      .wait_secs(wait_secs)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------ model
   // Cycle k after reset release has index k (1-based). Each input level is
   // seen by the debouncer two edges after it is sampled; a level is accepted
   // once DB consecutive delayed samples disagree with the accepted level.
   bit   m_valid = 0;
   int   m_cyc;
   bit   k_dq[$], c_dq[$], k_sh[$], c_sh[$];
   bit   k_db, c_db, fall_pend, m_req;
   bit   e_press;
   int   e_wait, hold;
   bit   e_tick, e_slow, e_req, e_car;

   function automatic bit all_differ(input bit q[$], input bit v);
      if (q.size() < DB) return 1'b0;
      foreach (q[i]) if (q[i] == v) return 1'b0;
      return 1'b1;
   endfunction

   initial forever begin
      bit cur_tick, cur_press, cur_req, ks, cs, c_fell;
      @(posedge clk);
      if (!rst_n) begin
         m_valid = 1; m_cyc = 1;
         k_dq = '{1'b1, 1'b1}; c_dq = '{1'b0, 1'b0};
         k_sh = {}; c_sh = {};
         k_db = 1; c_db = 0; fall_pend = 0; e_press = 0;
         m_req = 0; e_wait = 0; hold = 0;
      end else if (m_valid) begin
         cur_tick  = (m_cyc % DIV == 0);
         cur_press = e_press;
         cur_req   = m_req | e_press;
         m_req = cur_press | (m_req & !ped_clear);
         if (cur_press || ped_clear || !cur_req) e_wait = 0;
         else if (cur_tick && e_wait < 255) e_wait++;

         ks = k_dq.pop_front(); k_dq.push_back(key_n);
         k_sh.push_back(ks); if (k_sh.size() > DB) void'(k_sh.pop_front());
         e_press = fall_pend; fall_pend = 0;
         if (all_differ(k_sh, k_db)) begin
            k_db = !k_db;
            if (!k_db) fall_pend = 1;
         end

         cs = c_dq.pop_front(); c_dq.push_back(car_sw);
         c_sh.push_back(cs); if (c_sh.size() > DB) void'(c_sh.pop_front());
         c_fell = 0;
         if (all_differ(c_sh, c_db)) begin
            c_db = !c_db;
            c_fell = !c_db;
         end
         if (c_fell) hold = HOLD;
         else if (c_db) hold = 0;
         else if (cur_tick && hold > 0) hold--;
         m_cyc++;
      end
      e_tick = (m_cyc % DIV == 0);
      e_slow = ((m_cyc - 1) % DIV) >= DIV / 2;
      e_req  = m_req | e_press;
`ifdef TIC_CAR_HOLD_EN
      e_car  = c_db | (hold > 0);
`else
      e_car  = c_db;
`endif
   end

   initial forever begin
      @(negedge clk);
      if (m_valid) begin
         chk("tick", int'(tick), int'(e_tick));
         chk("slow_clk", int'(slow_clk), int'(e_slow));
         chk("ped_press", int'(ped_press), int'(e_press));
         chk("ped_req", int'(ped_req), int'(e_req));
         chk("car_present", int'(car_present), int'(e_car));
         chk("wait_secs", int'(wait_secs), e_wait);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
      $fatal(1);
   end

   // --------------------------------------------------------- stimulus
   task automatic find_press(output int at);
      at = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (ped_press) begin at = i; break; end
      end
   endtask

   task automatic wait_ticks(input int n);
      int nt = 0;
      int i  = 0;
      while (nt < n && i < n * DIV + 40) begin
         @(negedge clk); i++;
         if (tick) nt++;
      end
      chk("tick_budget", nt, n);
   endtask

   initial begin
      int k, at, tc;
      rst_n = 0; key_n = 1; car_sw = 0; ped_clear = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1;
      chk("reset_outputs", int'({tick, slow_clk, ped_press, ped_req, car_present, wait_secs}), 0);
      k = 1;
      while (!tick && k < 40) begin @(negedge clk); k++; end
      chk("first_tick_cycle", k, 20);

      // bounce: 3 low, 1 high, then held low
      @(negedge clk); key_n = 0;
      repeat (3) @(negedge clk);
      key_n = 1;
      @(negedge clk); key_n = 0;
      find_press(at);
      chk("press_latency", at, 7);
      chk("req_at_press", int'(ped_req), 1);

      wait_ticks(5);
      @(negedge clk);
      chk("wait_after_5", int'(wait_secs), 5);
      ped_clear = 1;
      @(negedge clk); ped_clear = 0;
      chk("req_after_clear", int'(ped_req), 0);
      chk("wait_after_clear", int'(wait_secs), 0);
      key_n = 1;

      // second press, wait to 9, then press coincident with clear
      repeat (10) @(negedge clk);
      key_n = 0;
      find_press(at);
      key_n = 1;
      wait_ticks(9);
      @(negedge clk);
      chk("wait_after_9", int'(wait_secs), 9);
      key_n = 0;
      find_press(at);
      chk("press_latency_2", at, 7);
      ped_clear = 1; key_n = 1;
      @(negedge clk); ped_clear = 0;
      chk("sim_req", int'(ped_req), 1);
      chk("sim_wait", int'(wait_secs), 0);

      // saturation then a one-cycle reset
      repeat (300 * DIV) @(negedge clk);
      chk("wait_saturated", int'(wait_secs), 255);
      rst_n = 0;
      @(negedge clk); rst_n = 1;
      chk("reset2_outputs", int'({tick, slow_clk, ped_press, ped_req, car_present, wait_secs}), 0);
      k = 1;
      while (!tick && k < 40) begin @(negedge clk); k++; end
      chk("tick_after_reset2", k, 20);

      // car sensor pulse
      @(negedge clk); car_sw = 1;
      repeat (10) @(negedge clk);
      car_sw = 0;
      k = 0; tc = 0;
      for (int i = 1; i <= 120; i++) begin
         @(negedge clk);
         if (!car_present) begin k = i; break; end
         if (tick && i >= 6) tc++;
      end
`ifdef TIC_CAR_HOLD_EN
      chk("car_hold_ticks", tc, 3);
`else
      chk("car_fall_cycle", k, 6);
`endif

      repeat (5) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
